// File: rtl/rll_key_unit_if.sv
// Key-delivery and locked-wire bundle for rll_key_unit.
// The master drives the key stream and lock_in; the slave returns the gated wires and status.
interface rll_key_unit_if #(
  parameter int unsigned KEY_WIDTH = 16
);
  logic                 key_load_start;
  logic                 key_valid;
  logic                 key_sdi;
  logic                 key_last;
  logic [KEY_WIDTH-1:0] lock_in;
  logic [KEY_WIDTH-1:0] lock_out;
  logic                 key_ready;
  logic                 key_err;
  logic                 busy;

  modport master (
    output key_load_start, key_valid, key_sdi, key_last, lock_in,
    input  lock_out, key_ready, key_err, busy
  );

  modport slave (
    input  key_load_start, key_valid, key_sdi, key_last, lock_in,
    output lock_out, key_ready, key_err, busy
  );
endinterface

// File: rtl/rll_key_unit.sv
// Serially loaded, parity-checked, double-buffered key register driving a bank
// of XOR/XNOR key gates on the locked wires of an rll16 core.
module rll_key_unit #(
  parameter int unsigned          KEY_WIDTH = 16,
  parameter logic [KEY_WIDTH-1:0] INV_MASK  = '0,
  parameter logic [KEY_WIDTH-1:0] RESET_KEY = '0
) (
  input  logic            clk,
  input  logic            rst,
  rll_key_unit_if.slave   bus
);

  localparam int unsigned          CNT_W   = $clog2(KEY_WIDTH + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(KEY_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, ERR} state_t;

  state_t               state_q, state_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [KEY_WIDTH-1:0] shift_q, shift_n;
  logic                 parity_q, parity_n;
  logic [KEY_WIDTH-1:0] active_key_q, active_key_n;
  logic                 key_ready_q, key_ready_n;
  logic [KEY_WIDTH-1:0] lock_out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      active_key_q <= RESET_KEY;
      key_ready_q  <= 1'b0;
      lock_out_q   <= '0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      shift_q      <= shift_n;
      parity_q     <= parity_n;
      active_key_q <= active_key_n;
      key_ready_q  <= key_ready_n;
      lock_out_q   <= bus.lock_in ^ active_key_q ^ INV_MASK;
    end
  end

  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    shift_n      = shift_q;
    parity_n     = parity_q;
    active_key_n = active_key_q;
    key_ready_n  = key_ready_q;

    // A start pulse restarts the frame from any state and wins over key_valid.
    if (bus.key_load_start) begin
      state_n  = SHIFT;
      cnt_n    = '0;
      shift_n  = '0;
      parity_n = 1'b0;
    end else begin
      case (state_q)
        SHIFT: begin
          if (bus.key_valid) begin
            if (cnt_q == CNT_MAX) begin
              parity_n = bus.key_sdi;
              state_n  = bus.key_last ? CHECK : ERR;
            end else begin
              for (int unsigned i = 0; i < KEY_WIDTH; i++) begin
                if (cnt_q == CNT_W'(i)) shift_n[i] = bus.key_sdi;
              end
              cnt_n = cnt_q + CNT_W'(1);
              if (bus.key_last) state_n = ERR;
            end
          end
        end
        CHECK: begin
          if ((^{shift_q, parity_q}) == 1'b0) begin
            active_key_n = shift_q;
            key_ready_n  = 1'b1;
            state_n      = IDLE;
          end else begin
            state_n = ERR;
          end
        end
        IDLE:    state_n = IDLE;
        ERR:     state_n = ERR;
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.lock_out  = lock_out_q;
  assign bus.key_ready = key_ready_q;
  assign bus.key_err   = (state_q == ERR);
  assign bus.busy      = (state_q == SHIFT) || (state_q == CHECK);

endmodule

// File: doc/rll_key_unit.md
Name: rll_key_unit

Overview:
- Sequential key-management and key-gating block for the rll16 locked-benchmark family.
- Replaces hard-wired key inputs with a serially loaded, parity-checked, double-buffered key register.
- Applies the active key to a parametrised bank of locked wires through XOR/XNOR key gates.
- Sits between the key-delivery path (scan/OTP reader) and the locked combinational core; its outputs feed the core's internal locked nets.

Parameters:
- KEY_WIDTH, 16, number of key bits and number of locked wires (1..64).
- INV_MASK, 16'h0000 (KEY_WIDTH bits), per-gate polarity; bit i = 1 makes gate i an XNOR key gate, 0 makes it XOR.
- RESET_KEY, 16'h0000 (KEY_WIDTH bits), value of the active key after reset.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_load_start  in  1  one-cycle pulse; starts a new key frame and aborts any frame in progress.
- key_valid  in  1  qualifies key_sdi; gaps between valid bits are allowed.
- key_sdi  in  1  serial key bit, LSB first, followed by one even-parity bit.
- key_last  in  1  marks the final (parity) bit; sampled only when key_valid = 1.
- lock_in  in  KEY_WIDTH  locked wires from the core.
- lock_out  out  KEY_WIDTH  key-gated wires to the core.
- key_ready  out  1  at least one valid key has been committed since reset.
- key_err  out  1  the last frame was rejected.
- busy  out  1  a frame is being received or checked.

Behaviour:
- Reset (asynchronous):
  - lock_out = 0, active_key = RESET_KEY, shift_reg = 0, bit counter = 0, FSM = IDLE.
  - key_ready = 0, key_err = 0, busy = 0.
- Gating:
  - lock_out <= lock_in ^ active_key ^ INV_MASK.
  - Registered, so latency is 1 cycle.
  - Updates every cycle in every FSM state.
- FSM states: IDLE, SHIFT, CHECK, ERR.
- IDLE:
  - key_load_start -> SHIFT; clear the counter and shift_reg; clear key_err.
- SHIFT (busy = 1):
  - On each key_valid: store key_sdi at index cnt for cnt < KEY_WIDTH; at cnt = KEY_WIDTH store the parity bit; then cnt++.
  - key_valid with key_last and cnt = KEY_WIDTH -> CHECK.
  - key_valid with key_last and cnt < KEY_WIDTH -> ERR.
  - key_valid at cnt = KEY_WIDTH without key_last -> ERR.
  - Counter width is $clog2(KEY_WIDTH+1); it never exceeds KEY_WIDTH.
- CHECK (busy = 1, exactly one cycle):
  - ^{shift_reg, parity} == 0: active_key <= shift_reg, key_ready <= 1, then -> IDLE.
  - Otherwise -> ERR with active_key unchanged.
  - The new key affects lock_out from the cycle after the CHECK edge.
- ERR (busy = 0):
  - key_err = 1; the state holds until key_load_start, which -> SHIFT and clears key_err.
- key_load_start in SHIFT or CHECK:
  - Aborts the frame and restarts SHIFT with a cleared counter; active_key is not touched.
  - Takes priority over a simultaneous key_valid; that bit is discarded.
- key_valid outside SHIFT is ignored.
- Double buffering: active_key changes only on a successful CHECK. lock_out stays on the old key throughout any reload, abort or error.
- key_ready is sticky and is cleared only by rst.
- rst mid-frame returns to reset values immediately; the partial frame is lost.

Test Plan:
- Reset with RESET_KEY = 0 and INV_MASK = 16'h00FF; drive lock_in = 16'h0000 -> after 1 clk, lock_out = 16'h00FF, key_ready = 0, key_err = 0, busy = 0.
- Pulse start; shift 16'h1234 LSB first plus parity bit 1 with key_last on the 17th bit; lock_in = 0 -> busy = 1 for 18 cycles, then key_ready = 1 and lock_out = 16'h12CB.
- Same frame with parity bit 0 -> key_err = 1, FSM = ERR, lock_out stays 16'h00FF, key_ready = 0.
- After committing 16'h1234, start a new frame and assert key_last on bit 9 -> key_err = 1 and lock_out stays 16'h12CB; then send a valid 16'hFFFF frame with parity 0 -> key_err = 0 and lock_out = 16'hFF00.
- Mid-frame (bit 7 of 16'hAAAA), assert key_load_start together with key_valid -> restart; then a full 16'h0001 frame with parity 1 commits and lock_out = 16'h00FE; also insert 3-cycle key_valid gaps, which must give the identical result.
- Assert rst during SHIFT after a committed key -> next cycle active_key = RESET_KEY, lock_out = 0, key_ready = 0, busy = 0.
